// File: rtl/h264dchadamard_if.sv
// Handshake bundle for the DC Hadamard block: input stream (ENABLE/XXIN/READYI)
// and output stream (VALID/YYOUT/YYLAST/READYO).
interface h264dchadamard_if #(
  parameter int WIDTH  = 16,
  parameter int OWIDTH = 16
);
  logic              MODE4;
  logic              READYI;
  logic              ENABLE;
  logic [WIDTH-1:0]  XXIN;
  logic              VALID;
  logic [OWIDTH-1:0] YYOUT;
  logic              YYLAST;
  logic              READYO;

  modport master (output MODE4, ENABLE, XXIN, READYO,
                  input  READYI, VALID, YYOUT, YYLAST);
  modport slave  (input  MODE4, ENABLE, XXIN, READYO,
                  output READYI, VALID, YYOUT, YYLAST);
endinterface

// File: rtl/h264dchadamard.sv
// 2x2 / 4x4 DC Hadamard transform, rows on load, columns on output.
// Optional H264DC_HALVE_EN: 4x4 outputs become (s+1)>>>1.
module h264dchadamard #(
  parameter int WIDTH    = 16,
  parameter int OWIDTH   = 16,
  parameter int TOGETHER = 0
) (
  input  logic CLK2,
  input  logic RESET,
  h264dchadamard_if.slave bus
);
  typedef logic signed [OWIDTH-1:0] sval_t;
  typedef enum logic {LOAD, OUT} state_t;

  function automatic sval_t kern4(input logic [1:0] r, input sval_t a, b, c, d);
    case (r)
      2'd0:    return a + b + c + d;
      2'd1:    return a + b - c - d;
      2'd2:    return a - b - c + d;
      default: return a - b + c - d;
    endcase
  endfunction

  function automatic sval_t kern2(input logic r, input sval_t a, b);
    return r ? a - b : a + b;
  endfunction

  state_t           state, state_nx;
  logic             enablei;
  logic [WIDTH-1:0] xxii;
  logic             mode_r;
  logic [3:0]       icnt, ocnt;
  sval_t            mem [16];
  sval_t            xext, col_s, yval, yyout_r;
  logic             valid_r, yylast_r;
  logic             wr, in_last, fire, out_last;
  logic [1:0]       orow, ocol;
  logic [3:0]       b4, b2;

  assign xext     = sval_t'($signed(xxii));
  assign wr       = enablei && (state == LOAD);
  assign in_last  = wr && (mode_r ? (icnt == 4'd15) : (icnt == 4'd3));
  assign out_last = mode_r ? (ocnt == 4'd15) : (ocnt == 4'd3);
  assign fire     = (state == OUT) && (bus.READYO || ((TOGETHER != 0) && (ocnt != 4'd0)));
  assign b4       = {icnt[3:2], 2'b00};
  assign b2       = {2'b00, icnt[1], 1'b0};

  always_ff @(posedge CLK2)
    if (RESET) state <= LOAD;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_last)           state_nx = OUT;
      default: if (fire && out_last)  state_nx = LOAD;
    endcase
  end

  // Row kernel is applied when the last value of a row arrives and written in place.
  always_ff @(posedge CLK2)
    if (!RESET && wr) begin
      if (mode_r && (icnt[1:0] == 2'd3)) begin
        for (int r = 0; r < 4; r++)
          mem[b4 | 4'(r)] <= kern4(2'(r), mem[b4], mem[b4 | 4'd1], mem[b4 | 4'd2], xext);
      end else if (!mode_r && icnt[0]) begin
        mem[b2]        <= kern2(1'b0, mem[b2], xext);
        mem[b2 | 4'd1] <= kern2(1'b1, mem[b2], xext);
      end else begin
        mem[icnt] <= xext;
      end
    end

  always_comb begin
    orow = 2'd0;
    ocol = 2'd0;
    if (mode_r) begin
      orow = ocnt[3:2];
      ocol = ocnt[1:0];
    end else begin
      orow = {1'b0, ocnt[1]};
      ocol = {1'b0, ocnt[0]};
    end
  end

  assign col_s = mode_r
    ? kern4(orow, mem[{2'd0, ocol}], mem[{2'd1, ocol}], mem[{2'd2, ocol}], mem[{2'd3, ocol}])
    : kern2(orow[0], mem[{3'b000, ocol[0]}], mem[{3'b001, ocol[0]}]);

`ifdef H264DC_HALVE_EN
  sval_t col_inc;
  assign col_inc = col_s + sval_t'(1);
  assign yval    = mode_r ? (col_inc >>> 1) : col_s;
`else
  assign yval    = col_s;
`endif

  always_ff @(posedge CLK2)
    if (RESET) begin
      enablei  <= 1'b0;
      xxii     <= '0;
      mode_r   <= 1'b0;
      icnt     <= 4'd0;
      ocnt     <= 4'd0;
      valid_r  <= 1'b0;
      yylast_r <= 1'b0;
      yyout_r  <= '0;
    end else begin
      enablei <= bus.ENABLE;
      xxii    <= bus.XXIN;
      if (wr) begin
        if (icnt == 4'd0) mode_r <= bus.MODE4;
        icnt <= in_last ? 4'd0 : icnt + 4'd1;
      end
      if (fire) begin
        yyout_r  <= yval;
        valid_r  <= 1'b1;
        yylast_r <= out_last;
        ocnt     <= out_last ? 4'd0 : ocnt + 4'd1;
      end else begin
        valid_r  <= 1'b0;
        yylast_r <= 1'b0;
      end
    end

  assign bus.READYI = (state == LOAD);
  assign bus.VALID  = valid_r;
  assign bus.YYOUT  = yyout_r;
  assign bus.YYLAST = yylast_r;
endmodule

// File: tb/tb_h264dchadamard.sv
// Bench for h264dchadamard: TOGETHER=0 and TOGETHER=1 instances share one input
// stream; outputs are scored against a matrix-product reference model.
module tb_h264dchadamard;
  localparam int W = 16, OW = 16;

  logic CLK2 = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK2 = ~CLK2;

  logic          mode4 = 1'b0, enable = 1'b0, readyo = 1'b1;
  logic [W-1:0]  xxin = '0;
  logic [1:0]    rdy, vld, lst;
  logic [1:0][OW-1:0] yo;

  int pass_cnt = 0, chk_cnt = 0, cyc = 0;
  logic [16:0] expq [2][$];
  int ro_mode = 0, blkn = 4, last_en_cyc = 0, lat_req = 0;
  int lat_ack = 0, gap = 0;
  int run [2], maxrun [2];
  logic [OW-1:0] held [2];
  logic seen [2];
  logic rst_s = 1'b1;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      h264dchadamard_if #(.WIDTH(W), .OWIDTH(OW)) bus();
      assign bus.MODE4  = mode4;
      assign bus.ENABLE = enable;
      assign bus.XXIN   = xxin;
      assign bus.READYO = readyo;
      assign rdy[g] = bus.READYI;
      assign vld[g] = bus.VALID;
      assign yo[g]  = bus.YYOUT;
      assign lst[g] = bus.YYLAST;
      h264dchadamard #(.WIDTH(W), .OWIDTH(OW), .TOGETHER(g)) dut (
        .CLK2(CLK2), .RESET(RESET), .bus(bus));
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  always @(posedge CLK2) begin
    cyc   <= cyc + 1;
    rst_s <= RESET;
  end

  // Output monitor and READYO generator, sampled 1ns after the edge.
  always @(posedge CLK2) begin
    logic [16:0] e;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst_s) begin
        held[i] = '0; seen[i] = 1'b0; run[i] = 0;
      end else if (vld[i]) begin
        if (expq[i].size() == 0) chk($sformatf("spurious%0d", i), 32'(vld[i]), 32'd0);
        else begin
          if (expq[i].size() == blkn) maxrun[i] = 0;
          e = expq[i].pop_front();
          chk($sformatf("yyout%0d", i), 32'(yo[i]), 32'(e[15:0]));
          chk($sformatf("yylast%0d", i), 32'(lst[i]), 32'(e[16]));
          if (i == 0 && lat_req != lat_ack) begin
            chk("latency", 32'(cyc - last_en_cyc), 32'd3);
            lat_ack = lat_req;
          end
        end
        held[i] = yo[i]; seen[i] = 1'b1;
        run[i]++;
        if (run[i] > maxrun[i]) maxrun[i] = run[i];
      end else begin
        run[i] = 0;
        if (i == 0 && seen[0]) chk("hold0", 32'(yo[0]), 32'(held[0]));
      end
    end
    if (gap > 0) gap--;
    if (ro_mode == 2 && !rst_s && vld[0] && expq[0].size() == blkn - 1) gap = 3;
    if (ro_mode == 1) readyo = ($urandom_range(0, 3) != 0);
    else              readyo = (gap == 0);
  end

  task automatic tick();
    @(posedge CLK2); #1;
  endtask

  // Reference: Y = H * X * H^T, wrapped to 16 bits, optional 4x4 halving.
  task automatic model(input bit m, input logic [15:0] v [16]);
    int h4 [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
    int h2 [2][2] = '{'{1, 1}, '{1, -1}};
    int n = m ? 4 : 2;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        int s = 0;
        logic signed [15:0] y;
        for (int i = 0; i < n; i++)
          for (int j = 0; j < n; j++) begin
            int xi = int'($signed(v[i*n+j]));
            s += (m ? h4[r][i] * h4[c][j] : h2[r][i] * h2[c][j]) * xi;
          end
        y = s[15:0];
`ifdef H264DC_HALVE_EN
        if (m) y = (y + 16'sd1) >>> 1;
`endif
        for (int k = 0; k < 2; k++)
          expq[k].push_back({(r == n-1) && (c == n-1), y});
      end
    blkn = n * n;
  endtask

  task automatic send(input bit m, input int nsend, input logic [15:0] v [16], input bit expect_out);
    int t = 0;
    while (rdy != 2'b11 && t < 200) begin tick(); t++; end
    if (t >= 200) chk("readyi_wait", 32'(rdy), 32'd3);
    if (expect_out) model(m, v);
    for (int i = 0; i < nsend; i++) begin
      mode4 = m; enable = 1'b1; xxin = v[i];
      if (expect_out && i == nsend - 1 && ro_mode != 1) begin
        last_en_cyc = cyc; lat_req++;
      end
      tick();
    end
    enable = 1'b0;
    if (expect_out) begin
      t = 0;
      while ((expq[0].size() != 0 || expq[1].size() != 0) && t < 400) begin tick(); t++; end
      if (t >= 400) chk("drain", 32'(expq[0].size() + expq[1].size()), 32'd0);
      tick();
    end
  endtask

  initial begin
    logic [15:0] v [16];
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v [16];
    repeat (3) tick();
    RESET = 1'b0;
    chk("rst_readyi", 32'(rdy), 32'd3);
    chk("rst_valid",  32'(vld), 32'd0);
    chk("rst_yylast", 32'(lst), 32'd0);
    chk("rst_yyout",  32'(yo),  32'd0);
    tick();

    v = '{default: 16'd0};
    for (int i = 0; i < 4; i++) v[i] = 16'(i + 1);
    send(1'b0, 4, v, 1'b1);

    for (int i = 0; i < 16; i++) v[i] = 16'(i);
    send(1'b1, 16, v, 1'b1);

    v = '{default: 16'd1};
    send(1'b1, 16, v, 1'b1);

    ro_mode = 2;
    for (int i = 0; i < 4; i++) v[i] = 16'(i + 1);
    send(1'b0, 4, v, 1'b1);
    chk("gap_run0", 32'(maxrun[0]), 32'd3);
    chk("gap_run1", 32'(maxrun[1]), 32'd4);
    ro_mode = 0;

    v = '{default: 16'h7FFF};
    send(1'b0, 4, v, 1'b1);

    for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
    send(1'b1, 7, v, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midrst_readyi", 32'(rdy), 32'd3);
    chk("midrst_valid",  32'(vld), 32'd0);
    chk("midrst_yylast", 32'(lst), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) v[i] = 16'(i + 1);
    send(1'b0, 4, v, 1'b1);

    ro_mode = 1;
    for (int b = 0; b < 24; b++) begin
      bit m = bit'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
      send(m, m ? 16 : 4, v, 1'b1);
    end
    ro_mode = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/h264dchadamard.md
# h264dchadamard

Parametrised DC Hadamard transform for the H264 encoder. One block serves both chroma DC (2x2) and Intra16x16 luma DC (4x4), selected per block. It sits between the DC collection stage and DC quantisation. It is self-inverse, with no quantisation, and transfers values one per CLK2 cycle with ready/valid handshakes on input and output.

## Interface
- WIDTH, 16: input sample width (signed).
- OWIDTH, 16: output and internal arithmetic width (signed); must be >= WIDTH.
- TOGETHER, 0: when 1, once a block's first output is issued the rest stream out on consecutive cycles regardless of READYO.
- CLK2  in  1  fast clock.
- RESET  in  1  reset, synchronous, active-high.
- MODE4  in  1  0 = 2x2 block, 1 = 4x4 block; sampled with the first input value of a block.
- READYI  out  1  high when ENABLE may be asserted.
- ENABLE  in  1  XXIN is valid this cycle.
- XXIN  in  WIDTH  input value, raster order.
- VALID  out  1  YYOUT is valid this cycle.
- YYOUT  out  OWIDTH  output value, raster order.
- YYLAST  out  1  high with VALID on the final value of a block.
- READYO  in  1  downstream can accept an output this cycle.

## Operation
- ENABLE and XXIN are registered once (enablei/xxii) before use. All storage after that is registered.
- The block has two states, LOAD and OUT. READYI = (state == LOAD).
- LOAD: each registered enable stores one value. The input counter runs 0..N-1, with N = 4 (2x2) or 16 (4x4). At count 0 the block latches MODE4 into mode_r.
- The row transform is applied as each row completes (2 or 4 values). Row results overwrite the row storage.
  - 2x2 row: [a+b, a-b].
  - 4x4 row: [a+b+c+d, a+b-c-d, a-b-c+d, a-b+c-d].
- When the last row's transform is written, the state becomes OUT and the output counter is 0.
- OUT: in each cycle where READYO=1, or where TOGETHER=1 and the output counter is not 0, the block emits one value. That value is the column transform of the stored rows, using the same kernel, at raster index k. It then increments k and sets VALID=1 on the next edge. Otherwise VALID=0 on the next edge.
- After the value at index N-1 is emitted, YYLAST=1 with it, state returns to LOAD, and both counters are 0.
- An enablei that arrives while in OUT is dropped. Upstream must honour READYI. The one-cycle input register means an ENABLE in the same cycle READYI falls is also dropped.
- Arithmetic: XXIN is sign-extended to OWIDTH. All sums and differences wrap modulo 2^OWIDTH. There is no saturation.
- With WIDTH=OWIDTH=16, TOGETHER=0 and MODE4=0, behaviour is cycle-identical to the existing 2x2 DC transform.

## Timing
- Reset values:
  - READYI=1 (LOAD), VALID=0, YYLAST=0, YYOUT=0.
  - Counters are 0 and enablei is 0.
  - Value storage is not cleared.
- Latency: the last input has ENABLE in cycle n. State is OUT from cycle n+2. The first VALID is in cycle n+3 if READYO=1 in cycle n+2.
- With READYO held at 1, output values are on consecutive cycles. Input for the next block is accepted (READYI=1) from the cycle after the YYLAST edge.
- READYO=0 mid-block with TOGETHER=0: YYOUT holds its last value, VALID=0, and k does not advance.
- RESET mid-block, in either state, takes priority over everything else. On the next edge: state LOAD, counters 0, VALID=0, YYLAST=0, and the partially loaded block is discarded.

## Configuration
- H264DC_HALVE_EN defined: in 4x4 mode only, each output is (s+1)>>>1, an arithmetic shift of the OWIDTH-bit column result s. This gives the forward luma DC scaling. 2x2 outputs are unchanged.
- H264DC_HALVE_EN undefined: all outputs are the raw column result s.

## Test plan
- 2x2, inputs 1,2,3,4, READYO=1 -> YYOUT 10,-2,-4,0 on VALID, YYLAST with 0, first VALID 3 cycles after the last ENABLE.
- 4x4, inputs 0..15, no HALVE -> 120,-16,0,-8,-64,0,0,0,0,0,0,0,-32,0,0,0.
- 4x4, all inputs 1 -> 16 then fifteen 0s. With H264DC_HALVE_EN -> 8 then fifteen 0s.
- 2x2 with TOGETHER=0, READYO low for 3 cycles after the first output -> VALID gaps, YYOUT held, order preserved. With TOGETHER=1, the same stimulus gives 4 consecutive VALIDs.
- 2x2, all inputs 16'h7FFF -> first output wraps to 16'hFFFC (-4).
- RESET asserted after 7 of 16 inputs, then a fresh 2x2 block 1,2,3,4 -> 10,-2,-4,0, no stale outputs.
